// File: rtl/mor1kx_tlb_reload_master_if.sv
// Signal bundle between the TLB-reload master, the two MMU page-table walkers and the memory read bus.
// The master modport is the reload master's view; the slave modport is the view of the walkers and bus.
interface mor1kx_tlb_reload_master_if #(
    parameter int OPTION_OPERAND_WIDTH = 32
);
    logic                            immu_req_i;
    logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i;
    logic                            immu_ack_o;
    logic [OPTION_OPERAND_WIDTH-1:0] immu_data_o;
    logic                            immu_err_o;
    logic                            dmmu_req_i;
    logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i;
    logic                            dmmu_ack_o;
    logic [OPTION_OPERAND_WIDTH-1:0] dmmu_data_o;
    logic                            dmmu_err_o;
    logic                            bus_req_o;
    logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o;
    logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i;
    logic                            bus_ack_i;
    logic                            bus_err_i;
    logic                            busy_o;

    modport master (
        input  immu_req_i, immu_addr_i, dmmu_req_i, dmmu_addr_i,
        input  bus_dat_i, bus_ack_i, bus_err_i,
        output immu_ack_o, immu_data_o, immu_err_o,
        output dmmu_ack_o, dmmu_data_o, dmmu_err_o,
        output bus_req_o, bus_addr_o, busy_o
    );

    modport slave (
        output immu_req_i, immu_addr_i, dmmu_req_i, dmmu_addr_i,
        output bus_dat_i, bus_ack_i, bus_err_i,
        input  immu_ack_o, immu_data_o, immu_err_o,
        input  dmmu_ack_o, dmmu_data_o, dmmu_err_o,
        input  bus_req_o, bus_addr_o, busy_o
    );
endinterface

// File: rtl/mor1kx_tlb_reload_master.sv
// Shared read master for IMMU/DMMU hardware TLB reloads: round-robin arbitration, walk locking,
// single-word bus reads with error and timeout reporting.
module mor1kx_tlb_reload_master #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_BUS_TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    mor1kx_tlb_reload_master_if.master    tlb
);
    localparam int W     = OPTION_OPERAND_WIDTH;
    localparam int CNT_W = (OPTION_BUS_TIMEOUT > 0) ? $clog2(OPTION_BUS_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((OPTION_BUS_TIMEOUT > 0) ? OPTION_BUS_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] TURN  = 2'd3;

    // owner_r / last_grant_r encoding: 0 = IMMU, 1 = DMMU
    logic [1:0]       state_r;
    logic             owner_r;
    logic             last_grant_r;
    logic             drop_r;
    logic [CNT_W-1:0] cnt_r;
    logic             bus_req_r;
    logic [W-1:0]     bus_addr_r;
    logic             busy_r;
    logic             immu_ack_r;
    logic             immu_err_r;
    logic [W-1:0]     immu_data_r;
    logic             dmmu_ack_r;
    logic             dmmu_err_r;
    logic [W-1:0]     dmmu_data_r;

    logic             owner_req_s;
    logic [W-1:0]     owner_addr_s;
    logic             grant_dmmu_s;
    logic [W-1:0]     grant_addr_s;
    logic             abort_s;
    logic             timeout_s;
    logic             done_s;
    logic             rsp_err_s;
    logic [W-1:0]     rsp_data_s;

    // Owner selection, arbitration and bus-completion decode
    always_comb begin
        owner_req_s  = 1'b0;
        owner_addr_s = {W{1'b0}};
        grant_addr_s = {W{1'b0}};
        timeout_s    = 1'b0;
        rsp_data_s   = {W{1'b0}};
        if (owner_r) begin
            owner_req_s  = tlb.dmmu_req_i;
            owner_addr_s = tlb.dmmu_addr_i;
        end else begin
            owner_req_s  = tlb.immu_req_i;
            owner_addr_s = tlb.immu_addr_i;
        end
        // On a tie the walker that was not served last wins
        grant_dmmu_s = tlb.dmmu_req_i & (~tlb.immu_req_i | ~last_grant_r);
        if (grant_dmmu_s) begin
            grant_addr_s = tlb.dmmu_addr_i;
        end else begin
            grant_addr_s = tlb.immu_addr_i;
        end
        abort_s = drop_r | ~owner_req_s;
        if (OPTION_BUS_TIMEOUT != 0) begin
            timeout_s = (cnt_r == CNT_LAST);
        end else begin
            timeout_s = 1'b0;
        end
        done_s    = tlb.bus_ack_i | tlb.bus_err_i | timeout_s;
        // Error wins over a simultaneous ack; a timeout has neither and also reports error
        rsp_err_s = tlb.bus_err_i | ~tlb.bus_ack_i;
        if (rsp_err_s) begin
            rsp_data_s = {W{1'b0}};
        end else begin
            rsp_data_s = tlb.bus_dat_i;
        end
    end

    // Walk FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            drop_r       <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            bus_req_r    <= 1'b0;
            bus_addr_r   <= {W{1'b0}};
            busy_r       <= 1'b0;
            immu_ack_r   <= 1'b0;
            immu_err_r   <= 1'b0;
            immu_data_r  <= {W{1'b0}};
            dmmu_ack_r   <= 1'b0;
            dmmu_err_r   <= 1'b0;
            dmmu_data_r  <= {W{1'b0}};
        end else begin
            immu_ack_r  <= 1'b0;
            immu_err_r  <= 1'b0;
            immu_data_r <= {W{1'b0}};
            dmmu_ack_r  <= 1'b0;
            dmmu_err_r  <= 1'b0;
            dmmu_data_r <= {W{1'b0}};
            case (state_r)
                IDLE: begin
                    if (tlb.immu_req_i | tlb.dmmu_req_i) begin
                        owner_r    <= grant_dmmu_s;
                        bus_addr_r <= grant_addr_s;
                        bus_req_r  <= 1'b1;
                        cnt_r      <= {CNT_W{1'b0}};
                        drop_r     <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ISSUE;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ISSUE: begin
                    drop_r <= abort_s;
                    if (done_s) begin
                        bus_req_r <= 1'b0;
                        state_r   <= RESP;
                        if (abort_s) begin
                            immu_ack_r <= 1'b0;
                        end else if (owner_r) begin
                            dmmu_ack_r  <= 1'b1;
                            dmmu_err_r  <= rsp_err_s;
                            dmmu_data_r <= rsp_data_s;
                        end else begin
                            immu_ack_r  <= 1'b1;
                            immu_err_r  <= rsp_err_s;
                            immu_data_r <= rsp_data_s;
                        end
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                RESP: begin
                    state_r <= TURN;
                end
                TURN: begin
                    // A still-asserted request is the next level of the same walk
                    if (owner_req_s && !drop_r) begin
                        bus_addr_r <= owner_addr_s;
                        bus_req_r  <= 1'b1;
                        cnt_r      <= {CNT_W{1'b0}};
                        state_r    <= ISSUE;
                    end else begin
                        last_grant_r <= owner_r;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    bus_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign tlb.immu_ack_o  = immu_ack_r;
    assign tlb.immu_data_o = immu_data_r;
    assign tlb.immu_err_o  = immu_err_r;
    assign tlb.dmmu_ack_o  = dmmu_ack_r;
    assign tlb.dmmu_data_o = dmmu_data_r;
    assign tlb.dmmu_err_o  = dmmu_err_r;
    assign tlb.bus_req_o   = bus_req_r;
    assign tlb.bus_addr_o  = bus_addr_r;
    assign tlb.busy_o      = busy_r;
endmodule

// File: tb/tb_mor1kx_tlb_reload_master.sv
// Randomized walker/bus stimulus; expected bus addresses and MMU responses are queued by the
// driver from a transaction-level arbitration model and checked by an independent monitor.
module tb_mor1kx_tlb_reload_master;
    localparam int W  = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mor1kx_tlb_reload_master_if #(.OPTION_OPERAND_WIDTH(W)) tif ();
    mor1kx_tlb_reload_master #(.OPTION_OPERAND_WIDTH(W), .OPTION_BUS_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .tlb (tif)
    );

    typedef struct packed {
        logic         who;
        logic         err;
        logic [W-1:0] data;
    } resp_t;

    logic [W-1:0] exp_addr_q[$];
    resp_t        exp_resp_q[$];
    int checks = 0;
    int failures = 0;
    int last_grant_m = 1;
    bit directed = 1'b0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_req(input int w, input logic v);
        if (w == 0) tif.immu_req_i = v;
        else        tif.dmmu_req_i = v;
    endtask

    task automatic set_addr(input int w, input logic [W-1:0] a);
        if (w == 0) tif.immu_addr_i = a;
        else        tif.dmmu_addr_i = a;
    endtask

    function automatic logic owner_ack(input int w);
        return (w == 0) ? tif.immu_ack_o : tif.dmmu_ack_o;
    endfunction

    // kind: 0 = ack, 1 = error (ack optionally also high), 2 = no bus response
    task automatic serve_level(input int w, input int kind, input int d, input logic [W-1:0] data,
                               input bit abort, input bit last, input logic [W-1:0] next_addr);
        int n;
        int hi;
        n = 0;
        while (!tif.bus_req_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tif.bus_req_o) begin
            check(1'b0, "grant_wait", 64'(n), 64'd20);
            return;
        end
        hi = 1;
        if (abort) set_req(w, 1'b0);
        if (kind == 2) begin
            while (tif.bus_req_o && hi <= TO + 4) begin
                @(negedge clk);
                if (tif.bus_req_o) hi++;
            end
            check(hi == TO, "timeout_len", 64'(hi), 64'(TO));
        end else begin
            repeat (d) @(negedge clk);
            tif.bus_dat_i = (kind == 0) ? data : W'($urandom);
            tif.bus_ack_i = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tif.bus_err_i = (kind == 1);
            @(negedge clk);
            tif.bus_ack_i = 1'b0;
            tif.bus_err_i = 1'b0;
            tif.bus_dat_i = W'($urandom);
        end
        check(owner_ack(w) == !abort, "ack_latency", 64'(owner_ack(w)), 64'(!abort));
        if (abort) check(!tif.immu_ack_o && !tif.dmmu_ack_o, "abort_no_ack",
                         64'({tif.immu_ack_o, tif.dmmu_ack_o}), 64'd0);
        if (!abort && !last) set_addr(w, next_addr);
        else                 set_req(w, 1'b0);
    endtask

    task automatic run_round(input bit use_i, input bit use_d);
        int           nlev [2];
        int           ab   [2];
        logic [W-1:0] addr [2][3];
        int           kind [2][3];
        int           dly  [2][3];
        logic [W-1:0] dat  [2][3];
        int           ord[$];
        resp_t        r;
        int           n;
        int           w;
        for (int i = 0; i < 2; i++) begin
            nlev[i] = $urandom_range(1, 3);
            ab[i]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nlev[i] - 1)) : -1;
            for (int l = 0; l < 3; l++) begin
                addr[i][l] = W'($urandom) & 32'hFFFF_FFFC;
                n          = $urandom_range(0, 5);
                kind[i][l] = (n < 4) ? 0 : (n == 4) ? 1 : 2;
                dly[i][l]  = $urandom_range(0, 3);
                dat[i][l]  = W'($urandom);
            end
        end
        if (directed) begin
            nlev[0] = 2; ab[0] = -1;
            addr[0][0] = 32'h0000_1000; addr[0][1] = 32'h0040_0008;
            kind[0][0] = 0; kind[0][1] = 0;
            dly[0][0] = 2; dat[0][0] = 32'hDEAD_2400;
        end
        if (use_i && use_d) begin
            if (last_grant_m == 0) ord = '{1, 0};
            else                   ord = '{0, 1};
        end else if (use_i) begin
            ord = '{0};
        end else begin
            ord = '{1};
        end
        foreach (ord[k]) begin
            w = ord[k];
            for (int l = 0; l < nlev[w]; l++) begin
                exp_addr_q.push_back(addr[w][l]);
                if (l == ab[w]) break;
                r.who  = w[0];
                r.err  = (kind[w][l] != 0);
                r.data = (kind[w][l] == 0) ? dat[w][l] : {W{1'b0}};
                exp_resp_q.push_back(r);
            end
        end
        if (use_i) begin set_addr(0, addr[0][0]); set_req(0, 1'b1); end
        if (use_d) begin set_addr(1, addr[1][0]); set_req(1, 1'b1); end
        foreach (ord[k]) begin
            w = ord[k];
            last_grant_m = w;
            for (int l = 0; l < nlev[w]; l++) begin
                serve_level(w, kind[w][l], dly[w][l], dat[w][l], l == ab[w], l == nlev[w] - 1,
                            (l + 1 < nlev[w]) ? addr[w][(l + 1) % 3] : {W{1'b0}});
                if (l == ab[w]) break;
            end
        end
        n = 0;
        while (tif.busy_o && n < 5) begin
            @(negedge clk);
            n++;
        end
        check(!tif.busy_o, "idle_return", 64'(tif.busy_o), 64'd0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // Scoreboard monitor: bus addresses on request rise, MMU responses on ack
    logic         prev_req = 1'b0;
    logic [W-1:0] cur_addr = '0;
    resp_t        exp_r;
    resp_t        act_r;
    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
        end else begin
            if (tif.bus_req_o) begin
                if (!prev_req) begin
                    if (exp_addr_q.size() == 0) begin
                        check(1'b0, "bus_addr_unexpected", 64'(tif.bus_addr_o), 64'd0);
                    end else begin
                        cur_addr = exp_addr_q.pop_front();
                        check(tif.bus_addr_o == cur_addr, "bus_addr", 64'(tif.bus_addr_o), 64'(cur_addr));
                    end
                end else begin
                    check(tif.bus_addr_o == cur_addr, "bus_addr_hold", 64'(tif.bus_addr_o), 64'(cur_addr));
                end
                check(tif.busy_o == 1'b1, "busy_during_req", 64'(tif.busy_o), 64'd1);
            end
            prev_req = tif.bus_req_o;
            if (tif.immu_ack_o || tif.dmmu_ack_o) begin
                check(!(tif.immu_ack_o && tif.dmmu_ack_o), "ack_exclusive",
                      64'({tif.immu_ack_o, tif.dmmu_ack_o}), 64'd1);
                act_r.who  = tif.dmmu_ack_o;
                act_r.err  = tif.dmmu_ack_o ? tif.dmmu_err_o : tif.immu_err_o;
                act_r.data = tif.dmmu_ack_o ? tif.dmmu_data_o : tif.immu_data_o;
                if (exp_resp_q.size() == 0) begin
                    check(1'b0, "ack_unexpected", 64'(act_r), 64'd0);
                end else begin
                    exp_r = exp_resp_q.pop_front();
                    check(act_r == exp_r, "ack_resp", 64'(act_r), 64'(exp_r));
                end
            end
            if (!tif.immu_ack_o)
                check(tif.immu_data_o == '0 && !tif.immu_err_o, "immu_idle_zero",
                      64'({tif.immu_err_o, tif.immu_data_o}), 64'd0);
            if (!tif.dmmu_ack_o)
                check(tif.dmmu_data_o == '0 && !tif.dmmu_err_o, "dmmu_idle_zero",
                      64'({tif.dmmu_err_o, tif.dmmu_data_o}), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        tif.immu_req_i = 1'b0; tif.immu_addr_i = '0;
        tif.dmmu_req_i = 1'b0; tif.dmmu_addr_i = '0;
        tif.bus_dat_i  = '0;   tif.bus_ack_i = 1'b0; tif.bus_err_i = 1'b0;
        repeat (3) @(negedge clk);
        check(!tif.bus_req_o, "rst_bus_req", 64'(tif.bus_req_o), 64'd0);
        check(tif.bus_addr_o == '0, "rst_bus_addr", 64'(tif.bus_addr_o), 64'd0);
        check(!tif.busy_o, "rst_busy", 64'(tif.busy_o), 64'd0);
        check(!tif.immu_ack_o && !tif.dmmu_ack_o, "rst_acks", 64'({tif.immu_ack_o, tif.dmmu_ack_o}), 64'd0);
        check(tif.immu_data_o == '0 && !tif.immu_err_o, "rst_immu_rsp", 64'(tif.immu_data_o), 64'd0);
        check(tif.dmmu_data_o == '0 && !tif.dmmu_err_o, "rst_dmmu_rsp", 64'(tif.dmmu_data_o), 64'd0);
        rst = 1'b1;

        directed = 1'b1;
        run_round(1'b1, 1'b1);
        directed = 1'b0;
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(1, 3);
            run_round(n[0], n[1]);
        end

        // Asynchronous reset between clock edges while a read is outstanding
        exp_addr_q.push_back(32'h0000_2000);
        tif.immu_addr_i = 32'h0000_2000;
        tif.immu_req_i  = 1'b1;
        n = 0;
        while (!tif.bus_req_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(tif.bus_req_o, "pre_reset_grant", 64'(tif.bus_req_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check(!tif.bus_req_o, "async_rst_bus_req", 64'(tif.bus_req_o), 64'd0);
        check(!tif.busy_o, "async_rst_busy", 64'(tif.busy_o), 64'd0);
        check(!tif.immu_ack_o && !tif.dmmu_ack_o, "async_rst_acks",
              64'({tif.immu_ack_o, tif.dmmu_ack_o}), 64'd0);
        tif.immu_req_i = 1'b0;
        tif.dmmu_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_grant_m = 1;
        run_round(1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check(exp_addr_q.size() == 0, "addr_queue_drain", 64'(exp_addr_q.size()), 64'd0);
        check(exp_resp_q.size() == 0, "resp_queue_drain", 64'(exp_resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
